retire_trace_monitor: RTL
=========================

Name: retire_trace_monitor

Overview:
- Synthesizable retirement monitor attached to RISC_V_Core's IF/ID outputs and hazard signals (stall, flush).
- Shadows the ID/EX, EX/MEM and MEM/WB stages to reconstruct the in-order retire stream.
- Maintains cycle, retired-instruction, bubble and drop counters, and detects end-of-program at a programmable PC.
- Buffers retire records in a small FIFO drained over a valid/ready port, for an on-chip trace/debug unit or a bench.

Parameters:
- ADDRESS_BITS, 20, width of PC fields.
- DATA_WIDTH, 32, instruction width.
- FIFO_DEPTH, 8, retire-record entries; power of two, at least 2.
- NOP_INSN, 32'h00000013, encoding injected for bubbles (addi x0,x0,0).

Ports:
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse arming the monitor (IDLE->RUN).
- end_pc  in  ADDRESS_BITS  PC whose retirement ends the run.
- ifid_instruction  in  DATA_WIDTH  core IF/ID instruction.
- ifid_pc  in  ADDRESS_BITS  core IF/ID PC.
- ifid_valid  in  1  IF/ID holds a real fetched instruction.
- stall  in  1  core ID-stage stall.
- flush  in  1  core branch/jump flush.
- trace_valid  out  1  FIFO head record available.
- trace_ready  in  1  consumer accepts head record.
- trace_pc  out  ADDRESS_BITS  head record PC.
- trace_instruction  out  DATA_WIDTH  head record instruction.
- cycle_count  out  32  cycles spent in RUN.
- instret_count  out  32  retired instructions in RUN.
- bubble_count  out  32  MEM/WB bubbles in RUN.
- drop_count  out  16  records lost to a full FIFO; saturating.
- done  out  1  high in DONE.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; all shadow stages hold NOP_INSN, PC 0, valid 0.
- Shadow pipeline runs in every state.
  - ID/EX <- IF/ID fields; on stall or flush it loads a bubble (NOP_INSN, PC 0, valid 0).
  - EX/MEM <- ID/EX; on flush it loads a bubble.
  - MEM/WB <- EX/MEM unconditionally.
- Latency: an IF/ID entry sampled at edge N is in MEM/WB after edge N+2 (absent stall/flush). Retire is evaluated in the cycle following edge N+2; the record is pushed at edge N+3 and trace_valid rises after edge N+3.
- retire = MEM/WB valid. A NOP_INSN encoding with valid=1 is a real retire; valid=0 is a bubble.
- FSM IDLE / RUN / DONE (encoded 2'd0 / 2'd1 / 2'd2):
  - IDLE: counters hold 0; no FIFO pushes; start -> RUN.
  - RUN: cycle_count +1 per cycle.
    - retire: instret_count +1 and push {pc, instruction}.
    - Bubble: bubble_count +1.
    - retire with MEM/WB PC == end_pc: the record is pushed and counted, then -> DONE on the same edge.
  - DONE: counters frozen, no pushes, done=1. FIFO continues to drain. Leaves DONE only on reset; start is ignored.
  - start while in RUN: ignored.
- cycle_count, instret_count and bubble_count wrap modulo 2^32.
- FIFO:
  - Registered outputs; first-word valid the cycle after push.
  - Pop when trace_valid && trace_ready.
  - Push and pop in the same cycle with the FIFO full: both occur, occupancy unchanged, no drop.
  - Push while full without a pop: record discarded, drop_count +1, saturating at 16'hFFFF.
  - Pop while empty: no effect.
  - trace_pc and trace_instruction hold their value while trace_valid=0.
- Reset mid-run: next cycle matches the reset state exactly, including an emptied FIFO with records discarded.

Decomposition:
- Package retire_monitor_pkg: NOP_INSN constant, FSM state encodings, record width (ADDRESS_BITS+DATA_WIDTH) and record pack/unpack functions.
- One sub-module, trace_fifo: parameterized synchronous FIFO with push, pop, full, empty and a count output.
- Shadow pipeline, FSM and counters stay in the top module.

Test Plan:
- Straight-line flow: start, then feed 5 valid IF/ID instructions at PCs 0x0,0x4,…,0x10 with no stall/flush → 5 records in order, each appearing 4 cycles after its IF/ID cycle; instret_count=5.
- Stall: hold stall=1 for 2 cycles mid-stream → 2 bubbles reach MEM/WB; bubble_count increments by 2; no duplicate records.
- Flush: assert flush for one cycle while PCs 0x8 and 0xC occupy IF/ID and ID/EX → neither 0x8 nor 0xC is recorded; bubble_count +2.
- End detection: end_pc=0xB0; a valid instruction at 0xB0 retires → record 0xB0 pushed; done=1 next cycle; cycle_count frozen; start pulse in DONE has no effect.
- FIFO pressure: trace_ready=0 with 10 retires and FIFO_DEPTH=8 → 8 records held, drop_count=2. Then trace_ready=1 while retiring into the full FIFO → simultaneous push/pop, no drop.
- Reset mid-run: reset after 3 retires with 3 records queued → next cycle all counters 0, trace_valid=0, done=0, state IDLE.

Source files
------------

// File: rtl/retire_monitor_pkg.sv
// Shared constants, FSM encoding and retire-record helpers for the retire trace monitor.
package retire_monitor_pkg;

    localparam int unsigned ADDRESS_BITS_DEF = 20;
    localparam int unsigned DATA_WIDTH_DEF   = 32;
    localparam int unsigned RECORD_WIDTH     = ADDRESS_BITS_DEF + DATA_WIDTH_DEF;

    localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [ADDRESS_BITS_DEF-1:0] pc;
        logic [DATA_WIDTH_DEF-1:0]   instruction;
    } trace_record_t;

    // Record layout is {pc, instruction} with the PC in the upper bits.
    function automatic logic [RECORD_WIDTH-1:0] pack_record(
        input logic [ADDRESS_BITS_DEF-1:0] pc,
        input logic [DATA_WIDTH_DEF-1:0]   instruction
    );
        trace_record_t rec;
        rec.pc          = pc;
        rec.instruction = instruction;
        return rec;
    endfunction

    function automatic trace_record_t unpack_record(input logic [RECORD_WIDTH-1:0] bits);
        return trace_record_t'(bits);
    endfunction

endpackage

// File: rtl/retire_trace_monitor_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO is visible the next cycle.
module trace_fifo #(
    parameter int unsigned WIDTH = 52,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next_c;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] kept_c;
    logic [CNT_W-1:0] count_next_c;

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        full_c       = (count == CNT_W'(DEPTH));
        empty_c      = (count == '0);
        do_pop_c     = pop && !empty_c;
        do_push_c    = push && (!full_c || do_pop_c);
        kept_c       = count - CNT_W'(do_pop_c);
        count_next_c = kept_c + CNT_W'(do_push_c);
        rd_next_c    = rd_ptr + PTR_W'(do_pop_c);
    end

    always_ff @(posedge clock) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head word bypasses storage when the incoming record becomes the only entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next_c;
            count  <= count_next_c;
            valid  <= (count_next_c != '0);
            if (count_next_c != '0) begin
                dout <= (kept_c == '0) ? din : mem[rd_next_c];
            end
        end
    end

endmodule

// File: rtl/retire_trace_monitor.sv
// Shadows the core's ID/EX, EX/MEM and MEM/WB stages to rebuild the retire stream,
// counts run statistics and queues retire records for a trace consumer.
module retire_trace_monitor
    import retire_monitor_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = ADDRESS_BITS_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(NOP_INSN_DEF)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] end_pc,
    input  logic [DATA_WIDTH-1:0]   ifid_instruction,
    input  logic [ADDRESS_BITS-1:0] ifid_pc,
    input  logic                    ifid_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [ADDRESS_BITS-1:0] trace_pc,
    output logic [DATA_WIDTH-1:0]   trace_instruction,
    output logic [31:0]             cycle_count,
    output logic [31:0]             instret_count,
    output logic [31:0]             bubble_count,
    output logic [15:0]             drop_count,
    output logic                    done
);

    localparam int unsigned REC_W      = ADDRESS_BITS + DATA_WIDTH;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0]   idex_insn,  exmem_insn,  memwb_insn;
    logic [ADDRESS_BITS-1:0] idex_pc,    exmem_pc,    memwb_pc;
    logic                    idex_valid, exmem_valid, memwb_valid;

    mon_state_t state;

    logic                  push_c;
    logic                  pop_c;
    logic                  drop_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic [REC_W-1:0]      fifo_dout;
    logic [FIFO_CNT_W-1:0] fifo_count_unused;

    // Shadow pipeline: runs in every state, mirrors the core's bubble injection.
    always_ff @(posedge clock) begin
        if (reset) begin
            idex_insn   <= NOP_INSN;
            idex_pc     <= '0;
            idex_valid  <= 1'b0;
            exmem_insn  <= NOP_INSN;
            exmem_pc    <= '0;
            exmem_valid <= 1'b0;
            memwb_insn  <= NOP_INSN;
            memwb_pc    <= '0;
            memwb_valid <= 1'b0;
        end else begin
            if (stall || flush) begin
                idex_insn  <= NOP_INSN;
                idex_pc    <= '0;
                idex_valid <= 1'b0;
            end else begin
                idex_insn  <= ifid_instruction;
                idex_pc    <= ifid_pc;
                idex_valid <= ifid_valid;
            end
            if (flush) begin
                exmem_insn  <= NOP_INSN;
                exmem_pc    <= '0;
                exmem_valid <= 1'b0;
            end else begin
                exmem_insn  <= idex_insn;
                exmem_pc    <= idex_pc;
                exmem_valid <= idex_valid;
            end
            memwb_insn  <= exmem_insn;
            memwb_pc    <= exmem_pc;
            memwb_valid <= exmem_valid;
        end
    end

    always_comb begin
        push_c = (state == ST_RUN) && memwb_valid;
        pop_c  = trace_ready && !fifo_empty_c;
        drop_c = push_c && fifo_full_c && !pop_c;
    end

    // Run FSM and statistics; the end-PC record is still counted and pushed on the final edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cycle_count   <= '0;
            instret_count <= '0;
            bubble_count  <= '0;
            drop_count    <= '0;
            done          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (memwb_valid) begin
                        instret_count <= instret_count + 32'd1;
                        if (memwb_pc == end_pc) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        bubble_count <= bubble_count + 32'd1;
                    end
                    if (drop_c && (drop_count != 16'hFFFF)) begin
                        drop_count <= drop_count + 16'd1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_c),
        .pop     (pop_c),
        .din     ({memwb_pc, memwb_insn}),
        .dout    (fifo_dout),
        .valid   (trace_valid),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count   (fifo_count_unused)
    );

    assign trace_pc          = fifo_dout[DATA_WIDTH +: ADDRESS_BITS];
    assign trace_instruction = fifo_dout[DATA_WIDTH-1:0];

endmodule
